// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit: next-PC generator and PC register for the single-cycle MIPS core,
//   with bne, jal/jalr link address, stall hold and a return-address stack checking jr.
// Optional build macro MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_VEC and pulse trap.
module pc_ctrl_unit #(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] RESET_PC  = 32'h00003000,
   parameter int          RAS_DEPTH = 4,
   parameter logic [31:0] TRAP_VEC  = 32'h00004180
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [2:0]        sel,
   input  logic [31:0]       Ins,
   input  logic              Zero,
   input  logic [31:0]       JRaddr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic [ADDR_W-1:0] link_addr,
   output logic              ras_valid,
   output logic [ADDR_W-1:0] ras_top,
   output logic              ras_miss,
   output logic [15:0]       miss_cnt,
   output logic              trap
);

   localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = SP_W + 1;
   localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];

   localparam logic [2:0] SEL_BEQ  = 3'b001;
   localparam logic [2:0] SEL_BNE  = 3'b010;
   localparam logic [2:0] SEL_J    = 3'b011;
   localparam logic [2:0] SEL_JAL  = 3'b100;
   localparam logic [2:0] SEL_JR   = 3'b101;
   localparam logic [2:0] SEL_JALR = 3'b110;

   logic [ADDR_W-1:0] pcadd4;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] j_tgt;
   logic [ADDR_W-1:0] jr_tgt;
   logic [ADDR_W-1:0] raw_tgt;
   logic              misalign;
   logic              is_jr;
   logic              is_push;
   logic              jr_miss;
   logic              unused_bits;

   // Return-address stack: sp indexes the most recent entry, cnt counts live entries
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [SP_W-1:0]   sp;
   logic [CNT_W-1:0]  cnt;

   assign pcadd4    = pc + ADDR_W'(4);
   assign link_addr = pcadd4;
   assign br_tgt    = pcadd4 + {{(ADDR_W-18){Ins[15]}}, Ins[15:0], 2'b00};
   assign j_tgt     = {pcadd4[ADDR_W-1:28], Ins[25:0], 2'b00};
   assign jr_tgt    = JRaddr[ADDR_W-1:0];

   assign is_jr     = (sel == SEL_JR);
   assign is_push   = (sel == SEL_JAL) || (sel == SEL_JALR);
   assign ras_valid = (cnt != '0);
   assign ras_top   = ras_valid ? ras_mem[sp] : '0;
   // A jr against an empty stack has nothing to predict, so it never counts as a miss
   assign jr_miss   = is_jr && ras_valid && (ras_top != jr_tgt);

   // Choose the raw target for the current selector
   always_comb begin
      raw_tgt = pcadd4;
      case (sel)
         SEL_BEQ:  if (Zero)  raw_tgt = br_tgt;
         SEL_BNE:  if (!Zero) raw_tgt = br_tgt;
         SEL_J,
         SEL_JAL:  raw_tgt = j_tgt;
         SEL_JR,
         SEL_JALR: raw_tgt = jr_tgt;
         default:  raw_tgt = pcadd4;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign misalign    = (raw_tgt[1:0] != 2'b00);
   assign npc         = misalign ? TRAP_VEC[ADDR_W-1:0] : raw_tgt;
   assign unused_bits = ^{Ins[31:26]};
`else
   assign misalign    = 1'b0;
   assign npc         = {raw_tgt[ADDR_W-1:2], 2'b00};
   assign unused_bits = ^{Ins[31:26], raw_tgt[1:0], TRAP_VEC, misalign};
`endif

   // PC register: reset vector, otherwise follow npc unless stalled
   always_ff @(posedge clk) begin
      if (rst)         pc <= PC_INIT;
      else if (!stall) pc <= npc;
   end

   // RAS update: push on jal/jalr (overwrite oldest when full), pop on jr when non-empty
   always_ff @(posedge clk) begin
      if (rst) begin
         sp  <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else if (!stall) begin
         if (is_push) begin
            sp                   <= sp + SP_W'(1);
            ras_mem[sp + SP_W'(1)] <= link_addr;
            if (cnt != CNT_W'(RAS_DEPTH)) cnt <= cnt + CNT_W'(1);
         end else if (is_jr && ras_valid) begin
            sp  <= sp - SP_W'(1);
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Status pulses and the saturating mispredict counter
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_miss <= 1'b0;
         trap     <= 1'b0;
         miss_cnt <= '0;
      end else if (stall) begin
         ras_miss <= 1'b0;
         trap     <= 1'b0;
      end else begin
         ras_miss <= jr_miss;
         trap     <= misalign;
         if (jr_miss && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// tb_pc_ctrl_unit: directed stimulus for pc_ctrl_unit (default parameters) with a
//   queue-based reference model compared every cycle on the falling edge, plus
//   hand-computed literal checks at the interesting points of the sequence.
module tb_pc_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [2:0]  sel;
   logic [31:0] ins;
   logic        zero;
   logic [31:0] jraddr;
   logic [31:0] pc, npc, link_addr, ras_top;
   logic        ras_valid, ras_miss, trap;
   logic [15:0] miss_cnt;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [31:0] mpc;
   logic [31:0] mras[$];
   logic [15:0] mcnt;
   logic        mmiss;
   logic        mtrap;

   pc_ctrl_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .sel(sel), .Ins(ins), .Zero(zero),
      .JRaddr(jraddr), .pc(pc), .npc(npc), .link_addr(link_addr),
      .ras_valid(ras_valid), .ras_top(ras_top), .ras_miss(ras_miss),
      .miss_cnt(miss_cnt), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // target chosen by the current selector, before alignment handling
   function automatic logic [31:0] m_target();
      logic [31:0] p4;
      logic [31:0] t;
      p4 = mpc + 32'd4;
      t  = p4;
      case (sel)
         3'd1: if (zero)  t = p4 + (32'($signed(ins[15:0])) << 2);
         3'd2: if (!zero) t = p4 + (32'($signed(ins[15:0])) << 2);
         3'd3, 3'd4: t = {p4[31:28], ins[25:0], 2'b00};
         3'd5, 3'd6: t = jraddr;
         default: t = p4;
      endcase
      return t;
   endfunction

   function automatic logic m_bad();
`ifdef MISALIGN_TRAP_EN
      return (m_target() % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] m_npc();
      logic [31:0] t;
      t = m_target();
`ifdef MISALIGN_TRAP_EN
      return ((t % 4) != 0) ? 32'h00004180 : t;
`else
      return t - (t % 4);
`endif
   endfunction

   function automatic logic [31:0] m_top();
      return (mras.size() > 0) ? mras[$] : 32'h0;
   endfunction

   task automatic model_update();
      logic [31:0] nxt;
      if (rst) begin
         mpc = 32'h00003000; mras.delete(); mcnt = 0; mmiss = 0; mtrap = 0;
      end else if (stall) begin
         mmiss = 0; mtrap = 0;
      end else begin
         nxt   = m_npc();
         mtrap = m_bad();
         mmiss = (sel == 3'd5) && (mras.size() > 0) && (mras[$] != jraddr);
         if (mmiss && mcnt != 16'hFFFF) mcnt = mcnt + 1;
         if (sel == 3'd5 && mras.size() > 0) void'(mras.pop_back());
         if (sel == 3'd4 || sel == 3'd6) begin
            mras.push_back(mpc + 32'd4);
            if (mras.size() > 4) void'(mras.pop_front());
         end
         mpc = nxt;
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", pc, mpc);
         chk("npc", npc, m_npc());
         chk("link_addr", link_addr, mpc + 32'd4);
         chk("ras_valid", {31'd0, ras_valid}, {31'd0, mras.size() > 0});
         chk("ras_top", ras_top, m_top());
         chk("ras_miss", {31'd0, ras_miss}, {31'd0, mmiss});
         chk("miss_cnt", {16'd0, miss_cnt}, {16'd0, mcnt});
         chk("trap", {31'd0, trap}, {31'd0, mtrap});
      end
   end

   task automatic drive(input logic [2:0] s, input logic [31:0] i, input logic z,
                        input logic [31:0] jr, input logic st, input logic r);
      sel = s; ins = i; zero = z; jraddr = jr; stall = st; rst = r;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step(input logic [2:0] s, input logic [31:0] i, input logic z,
                       input logic [31:0] jr, input logic st, input logic r);
      drive(s, i, z, jr, st, r);
      tick();
   endtask

   initial begin
      // 1: reset and sequential fetch
      step(3'd0, 0, 0, 0, 0, 1);
      chk_en = 1'b1;
      chk("rst_pc", pc, 32'h3000);
      chk("rst_ras_valid", {31'd0, ras_valid}, 32'd0);
      chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
      step(3'd0, 0, 0, 0, 0, 0);
      step(3'd7, 0, 0, 0, 0, 0);
      step(3'd0, 0, 0, 0, 0, 0);
      step(3'd7, 0, 0, 0, 0, 0);
      chk("seq4_pc", pc, 32'h3010);

      // 2: branch decisions observed on npc while stalled
      drive(3'd1, 32'h0000FFFF, 1, 0, 1, 0); #1;
      chk("beq_taken_npc", npc, 32'h3010);
      drive(3'd1, 32'h0000FFFF, 0, 0, 1, 0); #1;
      chk("beq_not_npc", npc, 32'h3014);
      drive(3'd2, 32'h0000FFFF, 0, 0, 1, 0); #1;
      chk("bne_taken_npc", npc, 32'h3010);
      drive(3'd2, 32'h0000FFFF, 1, 0, 1, 0); #1;
      chk("bne_not_npc", npc, 32'h3014);
      tick();
      chk("stall_hold_pc", pc, 32'h3010);

      // 3: jal / jr round trip
      step(3'd4, 32'h00000C40, 0, 0, 0, 0);
      chk("jal_pc", pc, 32'h3100);
      chk("jal_ras_top", ras_top, 32'h3014);
      step(3'd5, 0, 0, 32'h3014, 0, 0);
      chk("jr_pc", pc, 32'h3014);
      chk("jr_no_miss", {31'd0, ras_miss}, 32'd0);
      chk("jr_ras_empty", {31'd0, ras_valid}, 32'd0);

      // 4: overflow, matched returns, empty pop, then a real mispredict
      for (int k = 0; k < 5; k++) step(3'd4, 32'h00000C40 + 32'(k * 64), 0, 0, 0, 0);
      chk("ovf_ras_top", ras_top, 32'h3404);
      for (int k = 0; k < 4; k++) begin
         step(3'd5, 0, 0, 32'h3404 - 32'(k * 256), 0, 0);
         chk("ret_no_miss", {31'd0, ras_miss}, 32'd0);
      end
      step(3'd5, 0, 0, 32'h3018, 0, 0);
      chk("ret5_ras_valid", {31'd0, ras_valid}, 32'd0);
      chk("ret5_miss_cnt", {16'd0, miss_cnt}, 32'd0);
      chk("ret5_pc", pc, 32'h3018);
      step(3'd1, 32'h0000FFFD, 1, 0, 0, 0);
      chk("beq_back_pc", pc, 32'h3010);
      step(3'd4, 32'h00000C40, 0, 0, 0, 0);
      chk("jal2_ras_top", ras_top, 32'h3014);
      step(3'd5, 0, 0, 32'h3020, 0, 0);
      chk("miss_pulse", {31'd0, ras_miss}, 32'd1);
      chk("miss_cnt1", {16'd0, miss_cnt}, 32'd1);
      chk("miss_pc", pc, 32'h3020);
      step(3'd0, 0, 0, 0, 0, 0);
      chk("miss_pulse_end", {31'd0, ras_miss}, 32'd0);

      // 5: stall during jal, then reset with a full RAS
      step(3'd4, 32'h00000C40, 0, 0, 1, 0);
      chk("stall_jal_pc", pc, 32'h3024);
      chk("stall_jal_ras", {31'd0, ras_valid}, 32'd0);
      for (int k = 0; k < 4; k++) step(3'd4, 32'h00000C40, 0, 0, 0, 0);
      chk("full_ras_top", ras_top, 32'h3104);
      step(3'd4, 32'h00000C40, 0, 0, 1, 1);
      chk("rst_full_pc", pc, 32'h3000);
      chk("rst_full_ras", {31'd0, ras_valid}, 32'd0);
      chk("rst_full_cnt", {16'd0, miss_cnt}, 32'd0);

      // bne taken forward, jalr push
      step(3'd2, 32'h00000002, 0, 0, 0, 0);
      chk("bne_fwd_pc", pc, 32'h300C);
      step(3'd6, 0, 0, 32'h3200, 0, 0);
      chk("jalr_pc", pc, 32'h3200);
      chk("jalr_ras_top", ras_top, 32'h3010);

      // 6: misaligned jr target
      step(3'd5, 0, 0, 32'h3002, 0, 0);
`ifdef MISALIGN_TRAP_EN
      chk("misalign_pc", pc, 32'h4180);
      chk("misalign_trap", {31'd0, trap}, 32'd1);
`else
      chk("misalign_pc", pc, 32'h3000);
      chk("misalign_trap", {31'd0, trap}, 32'd0);
`endif

      // PC wraps modulo 2^32, then a plain j
      step(3'd5, 0, 0, 32'hFFFFFFFC, 0, 0);
      step(3'd0, 0, 0, 0, 0, 0);
      chk("wrap_pc", pc, 32'h0);
      step(3'd3, 32'h00000C00, 0, 0, 0, 0);
      chk("j_pc", pc, 32'h3000);
      step(3'd0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
